seq_bit_serializer: RTL and testbench

Upstream feeder for the serial-input sequence-detector FSMs. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock onto a single serial line, with a per-bit valid qualifier. Back-to-back words stream with no idle gap, so the downstream detector sees a continuous bit stream across word boundaries.

---
 rtl/seq_ser_pkg.sv | 16 +
 rtl/seq_bit_serializer.sv | 105 ++++++++++
 tb/tb_seq_bit_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the bit serializer feeding the sequence detectors.
package seq_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEF = 8;

    // A length of 0, or anything beyond the word, means "send the whole word".
    function automatic int unsigned len_norm(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word in, one bit per enabled clock out.
// Define SER_LSB_FIRST_EN to send bit 0 first (partial lengths right-justified).
module seq_bit_serializer
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic [CNT_W-1:0] s_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             word_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    ser_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             bit_nxt, vld_nxt, done_nxt;

    logic             accept;
    logic             last_bit;
    logic [CNT_W-1:0] len_load;
    logic             load_bit, head_bit;
    logic [WIDTH-1:0] load_rest, sreg_sh;

    // cnt counts the bits still to be shown, including the one on out_bit now.
    assign last_bit = (state == SHIFT) && (cnt == CNT_ONE);
    assign s_ready  = (state == IDLE) || (last_bit && en);
    assign accept   = s_valid && s_ready;
    assign busy     = (state == SHIFT);
    assign len_load = CNT_W'(len_norm(32'(s_len), 32'(WIDTH)));

`ifdef SER_LSB_FIRST_EN
    assign load_bit  = s_data[0];
    assign load_rest = {1'b0, s_data[WIDTH-1:1]};
    assign head_bit  = sreg[0];
    assign sreg_sh   = {1'b0, sreg[WIDTH-1:1]};
`else
    assign load_bit  = s_data[WIDTH-1];
    assign load_rest = {s_data[WIDTH-2:0], 1'b0};
    assign head_bit  = sreg[WIDTH-1];
    assign sreg_sh   = {sreg[WIDTH-2:0], 1'b0};
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        bit_nxt   = out_bit;
        vld_nxt   = out_valid;
        done_nxt  = word_done;
        if (accept) begin
            // Loading on the last-bit edge is what keeps words gap-free.
            state_nxt = SHIFT;
            cnt_nxt   = len_load;
            sreg_nxt  = load_rest;
            bit_nxt   = load_bit;
            vld_nxt   = 1'b1;
            done_nxt  = (len_load == CNT_ONE);
        end else if (state == SHIFT && en) begin
            if (cnt == CNT_ONE) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                sreg_nxt  = '0;
                bit_nxt   = 1'b0;
                vld_nxt   = 1'b0;
                done_nxt  = 1'b0;
            end else begin
                cnt_nxt   = cnt - CNT_ONE;
                sreg_nxt  = sreg_sh;
                bit_nxt   = head_bit;
                done_nxt  = (cnt == CNT_TWO);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sreg      <= sreg_nxt;
            out_bit   <= bit_nxt;
            out_valid <= vld_nxt;
            word_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: directed vector table plus stall/reset/detector sequences,
// with a bit-level scoreboard and a 1101 overlapping-detector model on the serial line.
module tb_seq_bit_serializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk, rst, s_valid, s_ready, en;
    logic [W-1:0]  s_data;
    logic [CW-1:0] s_len;
    logic          out_bit, out_valid, busy, word_done;

    seq_bit_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_len(s_len), .s_valid(s_valid),
        .s_ready(s_ready), .en(en), .out_bit(out_bit), .out_valid(out_valid),
        .busy(busy), .word_done(word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  d;
        logic [CW-1:0] l;
        logic [W-1:0]  e;   // expected stream, first bit in e[W-1]
        int            n;
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0;
    int   vcnt = 0, vrise = 0, done_cnt = 0, mcnt = 0;
    logic [15:0] mmask = '0;
    logic [3:0]  hist = '0;
    logic        pv = 1'b0, started = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [CW-1:0] l,
                        input logic [W-1:0] e, input int n);
        s_data  = d;
        s_len   = l;
        s_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            #3;
            if (s_ready) begin
                for (int i = 0; i < n; i++) begin
                    exp_t x;
                    x.b    = e[W-1-i];
                    x.last = (i == n - 1);
                    q.push_back(x);
                end
                @(posedge clk); #1;
                s_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        chk("accept_timeout", 32'(s_ready), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor and downstream detector model, sampled mid-cycle.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 0);
                end else begin
                    chk("out_bit", 32'(out_bit), 32'(q[0].b));
                    chk("word_done", 32'(word_done), 32'(q[0].last));
                    if (en) void'(q.pop_front());
                end
            end else begin
                chk("idle_bit", 32'(out_bit), 0);
                chk("idle_done", 32'(word_done), 0);
            end
            if (en) begin
                hist = {hist[2:0], out_bit};
                if (hist == 4'b1101) begin
                    mcnt++;
                    if (out_valid && vcnt < 16) mmask[vcnt] = 1'b1;
                end
            end
            if (word_done) done_cnt++;
            if (out_valid) begin
                vcnt++;
                if (!pv) vrise++;
            end
            pv = out_valid;
        end
    end

    vec_t vt[6];
    logic [W-1:0] w5a, w5b;

    initial begin
`ifdef SER_LSB_FIRST_EN
        vt[0] = '{8'b0000_1011, 4'd4,  8'b1101_0000, 4};
        vt[4] = '{8'h6B,        4'd15, 8'hD6,        8};
        w5a = 8'b0101_1011;
        w5b = 8'b0000_0011;
`else
        vt[0] = '{8'b1101_0000, 4'd4,  8'b1101_0000, 4};
        vt[4] = '{8'h6B,        4'd15, 8'h6B,        8};
        w5a = 8'b1101_1010;
        w5b = 8'b1100_0000;
`endif
        vt[1] = '{8'hA5, 4'd0, 8'hA5, 8};
        vt[2] = '{8'h3C, 4'd8, 8'h3C, 8};
        vt[3] = '{8'h81, 4'd1, 8'h80, 1};
        vt[5] = '{8'hFF, 4'd9, 8'hFF, 8};

        rst = 1'b1; en = 1'b1; s_valid = 1'b0; s_data = '0; s_len = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        started = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_bit", 32'(out_bit), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_word_done", 32'(word_done), 0);
        @(posedge clk); #1;

        // 4-bit word: 1-cycle latency, done on 4th bit, idle after.
        send(vt[0].d, vt[0].l, vt[0].e, vt[0].n);
        @(negedge clk);
        chk("t1_first_valid", 32'(out_valid), 1);
        chk("t1_busy", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("t1_done_k4", 32'(word_done), 1);
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_valid", 32'(out_valid), 0);
        chk("t1_idle_ready", 32'(s_ready), 1);
        @(posedge clk); #1;

        // Table: all vectors offered back to back.
        vcnt = 0;
        for (int i = 0; i < 6; i++) send(vt[i].d, vt[i].l, vt[i].e, vt[i].n);
        idle(12);
        chk("tbl_drained", 32'(q.size()), 0);
        chk("tbl_bits", 32'(vcnt), 37);

        // Two full words with no gap between them.
        vcnt = 0; vrise = 0; done_cnt = 0;
        send(8'hA5, 4'd0, 8'hA5, 8);
        send(8'h3C, 4'd8, 8'h3C, 8);
        idle(12);
        chk("b2b_bits", 32'(vcnt), 16);
        chk("b2b_gapless", 32'(vrise), 1);
        chk("b2b_done_pulses", 32'(done_cnt), 2);

        // Stall three cycles while bit 2 is on the line.
        vcnt = 0;
        send(8'hF0, 4'd8, 8'hF0, 8);
        idle(2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold_bit", 32'(out_bit), 1);
            chk("stall_hold_valid", 32'(out_valid), 1);
            @(posedge clk); #1;
        end
        en = 1'b1;
        idle(12);
        chk("stall_valid_cycles", 32'(vcnt), 11);
        chk("stall_drained", 32'(q.size()), 0);

        // Reset while bit 3 is on the line.
        done_cnt = 0;
        send(8'hFF, 4'd8, 8'hFF, 8);
        idle(3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_bit", 32'(out_bit), 0);
        chk("mrst_ready", 32'(s_ready), 1);
        chk("mrst_busy", 32'(busy), 0);
        @(posedge clk); #1;
        idle(10);
        chk("mrst_no_done", 32'(done_cnt), 0);

        // Continuous stream into the 1101 detector model.
        vcnt = 0; mcnt = 0; mmask = '0;
        send(w5a, 4'd8, 8'b1101_1010, 8);
        send(w5b, 4'd8, 8'b1100_0000, 8);
        idle(20);
        chk("det_match_count", 32'(mcnt), 2);
        chk("det_match_pos", 32'(mmask), 32'h0048);
        chk("det_drained", 32'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
